icache_refill: RTL and testbench
================================

Name: icache_refill

Overview:
Instruction-cache refill controller sitting directly upstream of the fetch stage's instruction cache. It captures a fetch miss and reads the four 32b words of the missing line from backing instruction memory, one beat at a time. It then assembles a 128b line and issues a one-cycle cache write with a fully formed 9b line tag. While it is busy it stalls fetch, and it supports abort on flush and a memory timeout.

Parameters:
ADDR_W, 5, instruction word address width (PC width)
DATA_W, 32, instruction word width
LINE_WORDS, 4, words per cache line (offset = PC[1:0])
MEM_TIMEOUT, 15, max cycles waiting for mem_rvalid on one beat before abort

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
miss  in  1  fetch cache miss, level
miss_pc  in  5  PC of missing instruction
flush  in  1  pipeline redirect; abandon refill in progress
mem_req  out  1  read request to instruction memory
mem_addr  out  5  word address of current beat
mem_rvalid  in  1  read data valid for current beat
mem_rdata  in  32  read data
wr_en  out  1  cache line write strobe (1 cycle)
wr_line  out  128  assembled line
wr_tag  out  9  line tag {valid, lru_cnt[2:0], tag[2:0], off[1:0]}
busy  out  1  refill in progress; fetch must hold PC/enable low
err  out  1  one-cycle pulse on memory timeout abort

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_req=0, mem_addr=0, wr_en=0, wr_line=0, wr_tag=0, busy=0, err=0; beat and timeout counters cleared. A reset mid-refill discards the partial line; no write is issued.
- States: IDLE, FILL, DRAIN, WRITE, HOLD.
- IDLE: if miss=1 and flush=0, latch base = {miss_pc[4:2],2'b00}, clear beat=0, go to FILL. miss together with flush stays in IDLE.
- FILL: mem_req=1 and mem_addr=base+beat, both registered and stable until mem_rvalid. Only one beat is in flight. mem_rvalid may arrive in the first FILL cycle (zero-wait).
  - On mem_rvalid: store mem_rdata into wr_line[32*beat+31:32*beat], increment beat, and reset the timeout counter.
  - After beat 3 is accepted: mem_req=0, go to WRITE.
- FILL timeout: the counter increments each FILL cycle without mem_rvalid. On reaching MEM_TIMEOUT, go to IDLE, pulse err=1 for exactly 1 cycle, drop mem_req, and do not write.
- FILL with flush=1: if mem_rvalid is in the same cycle, go to IDLE with data discarded. Otherwise go to DRAIN.
- DRAIN: mem_req=0, wait for mem_rvalid of the outstanding beat (data discarded), then go to IDLE. The timeout also applies here; timeout exits to IDLE with err=1.
- WRITE: wr_en=1 for exactly one cycle. wr_tag = {1'b1, 3'd0, base[4:2], 2'b00}. wr_line is the full assembled line. flush in WRITE is ignored, because the line is valid regardless of redirect.
- HOLD: one cycle with wr_en=0 and miss ignored, so the cache tag update becomes visible before a re-miss is evaluated. Then go to IDLE.
- busy=1 in every state except IDLE, registered with the state.
- A miss arriving while not in IDLE is ignored. Fetch is stalled by busy, so miss re-presents after HOLD if it is still valid.
- Beat counter is 2b and wraps from 3 to 0 only on the FILL→WRITE transition.
- mem_addr arithmetic is 5b. base+beat never carries out of the line because base[1:0]=0.
- Zero-wait latency: miss sampled at cycle 0, FILL cycles 1..4, wr_en at cycle 5, HOLD at cycle 6, IDLE at cycle 7.

Decomposition:
- Shared package holds:
  - state encoding enum (IDLE/FILL/DRAIN/WRITE/HOLD)
  - LINE_W=128 and TAG_W=9
  - tag field position constants: VALID_BIT=8, LRU_HI=7, LRU_LO=5, TAG_HI=4, TAG_LO=2, OFF_HI=1, OFF_LO=0
  - a function building a line tag from a PC
- One natural sub-module: icache_line_asm, the 4-beat word-to-line shift/insert register with beat counter. The FSM and timeout stay in the top module.

Test Plan:
- Zero-wait refill: miss=1, miss_pc=5'd13; memory returns 32'hA0+addr the same cycle. Required: mem_addr 12,13,14,15 on cycles 1..4; wr_en at cycle 5; wr_line={32'hAF,32'hAE,32'hAD,32'hAC}; wr_tag=9'b1_000_011_00; busy high on cycles 1..6.
- Variable latency: miss_pc=5'd2, rvalid delays 0,3,1,5. Required: mem_addr holds each value until its rvalid; single wr_en; wr_tag=9'b1_000_000_00; no err.
- Timeout: miss_pc=5'd20, rvalid never asserts. Required: mem_req high for 15 cycles, err pulses once, mem_req drops, return to IDLE, wr_en never set.
- Flush mid-fill: flush after beat 1 with beat 2 outstanding. Required: DRAIN with mem_req=0; the rvalid 2 cycles later is consumed; IDLE follows; no wr_en; a new miss afterwards starts a fresh refill at its own base.
- Async reset in FILL: rst_n low after beat 2 and held 3 cycles. Required: all outputs 0 immediately; no wr_en after release; stray mem_rvalid in IDLE ignored.
- Miss while busy: a second miss_pc=5'd8 during FILL for pc 4. Required: only line base 4 is written; the second miss is ignored until after HOLD.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// rtl/icache_refill_pkg.sv - shared types, line/tag geometry and tag builder for the icache refill slice
package icache_refill_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WRITE = 3'd3,
      ST_HOLD  = 3'd4
   } refillState_t;

   localparam int LINE_W    = 128;
   localparam int TAG_W     = 9;

   localparam int VALID_BIT = 8;
   localparam int LRU_HI    = 7;
   localparam int LRU_LO    = 5;
   localparam int TAG_HI    = 4;
   localparam int TAG_LO    = 2;
   localparam int OFF_HI    = 1;
   localparam int OFF_LO    = 0;

   // Builds a freshly filled line tag from the PC's line-index bits (PC[4:2]).
   // The LRU age starts at zero and the offset field always names word 0.
   function automatic logic [TAG_W-1:0] makeLineTag(input logic [TAG_HI-TAG_LO:0] pcLine);
      logic [TAG_W-1:0] t;
      t                = '0;
      t[VALID_BIT]     = 1'b1;
      t[LRU_HI:LRU_LO] = '0;
      t[TAG_HI:TAG_LO] = pcLine;
      t[OFF_HI:OFF_LO] = '0;
      return t;
   endfunction

endpackage

// File: rtl/icache_line_asm.sv
// rtl/icache_line_asm.sv - word-by-word line assembly register with beat counter
module icache_line_asm #(
   parameter int DATA_W = 32,
   parameter int WORDS  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       store,
   input  logic [DATA_W-1:0]          data,
   output logic [$clog2(WORDS)-1:0]   beat,
   output logic [DATA_W*WORDS-1:0]    line
);

   // Insert each accepted word at the current beat slot; the counter wraps
   // naturally after the last word, so it is already zero for the next line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat <= '0;
         line <= '0;
      end else if (clear) begin
         beat <= '0;
      end else if (store) begin
         line[beat*DATA_W +: DATA_W] <= data;
         beat                        <= beat + 1'b1;
      end
   end

endmodule

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - instruction cache miss refill controller (FSM, timeout, line write)
module icache_refill
   import icache_refill_pkg::*;
#(
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 32,
   parameter int LINE_WORDS  = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss,
   input  logic [ADDR_W-1:0] miss_pc,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wr_en,
   output logic [LINE_W-1:0] wr_line,
   output logic [TAG_W-1:0]  wr_tag,
   output logic              busy,
   output logic              err
);

   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam int TO_W   = $clog2(MEM_TIMEOUT + 1);

   refillState_t      state;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] missBase;
   logic [BEAT_W-1:0] beat;
   logic [BEAT_W-1:0] nextBeat;
   logic [TO_W-1:0]   toCnt;
   logic              timeoutHit;
   logic              lastBeat;
   logic              startFill;
   logic              storeBeat;

   // The word offset of the missing PC is irrelevant: the whole line is fetched from word 0.
   wire unusedPcOff = &{1'b0, miss_pc[BEAT_W-1:0]};

   assign missBase   = {miss_pc[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}};
   assign nextBeat   = beat + 1'b1;
   assign lastBeat   = (beat == BEAT_W'(LINE_WORDS - 1));
   assign timeoutHit = (toCnt == TO_W'(MEM_TIMEOUT - 1));
   assign startFill  = (state == ST_IDLE) && miss && !flush;
   // A beat returning together with a flush is discarded, never stored.
   assign storeBeat  = (state == ST_FILL) && mem_rvalid && !flush;

   icache_line_asm #(
      .DATA_W (DATA_W),
      .WORDS  (LINE_WORDS)
   ) u_lineAsm (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (startFill),
      .store (storeBeat),
      .data  (mem_rdata),
      .beat  (beat),
      .line  (wr_line)
   );

   // Refill sequencing: request one beat at a time, abort on flush or timeout, then write and hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         base     <= '0;
         toCnt    <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         wr_en    <= 1'b0;
         wr_tag   <= '0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (startFill) begin
                  base     <= missBase;
                  mem_addr <= missBase;
                  mem_req  <= 1'b1;
                  busy     <= 1'b1;
                  toCnt    <= '0;
                  state    <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (mem_rvalid) begin
                  toCnt <= '0;
                  if (flush) begin
                     mem_req <= 1'b0;
                     busy    <= 1'b0;
                     state   <= ST_IDLE;
                  end else if (lastBeat) begin
                     mem_req <= 1'b0;
                     wr_en   <= 1'b1;
                     wr_tag  <= makeLineTag(base[ADDR_W-1:BEAT_W]);
                     state   <= ST_WRITE;
                  end else begin
                     mem_addr <= base + ADDR_W'(nextBeat);
                  end
               end else if (timeoutHit) begin
                  toCnt   <= '0;
                  mem_req <= 1'b0;
                  busy    <= 1'b0;
                  err     <= 1'b1;
                  state   <= ST_IDLE;
               end else begin
                  // The outstanding beat keeps aging across a flush into DRAIN.
                  toCnt <= toCnt + 1'b1;
                  if (flush) begin
                     mem_req <= 1'b0;
                     state   <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (mem_rvalid) begin
                  toCnt <= '0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (timeoutHit) begin
                  toCnt <= '0;
                  busy  <= 1'b0;
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  toCnt <= toCnt + 1'b1;
               end
            end
            ST_WRITE: begin
               state <= ST_HOLD;
            end
            ST_HOLD: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               mem_req <= 1'b0;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - scoreboard bench for the icache refill controller
module tb_icache_refill;

   typedef struct {
      logic [127:0] line;
      logic [8:0]   tag;
   } expLine_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         miss = 1'b0;
   logic [4:0]   miss_pc = '0;
   logic         flush = 1'b0;
   logic         mem_req;
   logic [4:0]   mem_addr;
   logic         mem_rvalid = 1'b0;
   logic [31:0]  mem_rdata = '0;
   logic         wr_en;
   logic [127:0] wr_line;
   logic [8:0]   wr_tag;
   logic         busy;
   logic         err;

   int nVec = 0;
   int nFail = 0;
   int wrCount = 0;
   int errCount = 0;
   int beatSeen = 0;
   bit memOn = 1'b0;
   bit forceValid = 1'b0;
   int delayQ[$];
   int waitLeft = -1;
   expLine_t expQ[$];

   icache_refill dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .miss       (miss),
      .miss_pc    (miss_pc),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .wr_en      (wr_en),
      .wr_line    (wr_line),
      .wr_tag     (wr_tag),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tagName, input logic [127:0] obs, input logic [127:0] exp);
      nVec++;
      if (obs !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h want %0h at %0t", tagName, obs, exp, $time);
      end
   endtask

   task automatic pushExp(input logic [4:0] pc);
      expLine_t e;
      logic [4:0] b;
      b = {pc[4:2], 2'b00};
      for (int i = 0; i < 4; i++) e.line[32*i +: 32] = 32'hA0 + 32'(b) + 32'(i);
      e.tag = {1'b1, 3'b000, pc[4:2], 2'b00};
      expQ.push_back(e);
   endtask

   task automatic driveMiss(input logic [4:0] pc, input bit expectWrite);
      miss     = 1'b1;
      miss_pc  = pc;
      beatSeen = 0;
      if (expectWrite) pushExp(pc);
      @(posedge clk);
      #1 miss = 1'b0;
   endtask

   task automatic waitIdle(input int maxCyc);
      for (int i = 0; i < maxCyc; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      checkVal("idleTimeout", 1, 0);
   endtask

   // Memory model: one beat answered after its programmed delay, data = A0 + address.
   initial forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (forceValid) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hDEAD_BEEF;
      end else if (mem_req && memOn) begin
         if (waitLeft < 0) waitLeft = (delayQ.size() > 0) ? delayQ.pop_front() : 0;
         if (waitLeft == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hA0 + {27'd0, mem_addr};
            waitLeft   = -1;
         end else begin
            waitLeft--;
         end
      end else begin
         waitLeft = -1;
      end
   end

   // Beats accepted by the DUT (sampled at the active edge, before it updates).
   initial forever begin
      @(posedge clk);
      if (mem_req && mem_rvalid) beatSeen++;
   end

   // Output monitor: every line write is popped against the scoreboard.
   initial forever begin
      expLine_t e;
      @(negedge clk);
      if (err) errCount++;
      if (wr_en) begin
         wrCount++;
         if (expQ.size() == 0) begin
            checkVal("wrUnexpected", 1, 0);
         end else begin
            e = expQ.pop_front();
            checkVal("wrLine", wr_line, e.line);
            checkVal("wrTag", 128'(wr_tag), 128'(e.tag));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish by 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      int reqCyc;
      int errBefore;
      bit found;

      // Reset state
      #12;
      checkVal("rstReq", 128'(mem_req), 0);
      checkVal("rstAddr", 128'(mem_addr), 0);
      checkVal("rstWrEn", 128'(wr_en), 0);
      checkVal("rstLine", wr_line, 0);
      checkVal("rstTag", 128'(wr_tag), 0);
      checkVal("rstBusy", 128'(busy), 0);
      checkVal("rstErr", 128'(err), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Zero-wait refill of pc 13
      memOn = 1'b1;
      delayQ.delete();
      driveMiss(5'd13, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkVal("zwAddr", 128'(mem_addr), 128'(12 + i));
         checkVal("zwReq", 128'(mem_req), 1);
         checkVal("zwBusy", 128'(busy), 1);
      end
      @(negedge clk);
      checkVal("zwWrEn", 128'(wr_en), 1);
      checkVal("zwBusyW", 128'(busy), 1);
      @(negedge clk);
      checkVal("zwHoldWr", 128'(wr_en), 0);
      checkVal("zwBusyH", 128'(busy), 1);
      @(negedge clk);
      checkVal("zwIdle", 128'(busy), 0);
      checkVal("zwWrites", wrCount, 1);

      // Variable latency refill of pc 2
      delayQ = '{0, 3, 1, 5};
      @(posedge clk);
      #1 driveMiss(5'd2, 1'b1);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (mem_req) checkVal("vlHoldAddr", 128'(mem_addr), 128'(beatSeen));
         if (!busy) break;
      end
      checkVal("vlIdle", 128'(busy), 0);
      checkVal("vlWrites", wrCount, 2);
      checkVal("vlErr", errCount, 0);

      // Timeout on pc 20
      memOn = 1'b0;
      errBefore = errCount;
      reqCyc = 0;
      @(posedge clk);
      #1 driveMiss(5'd20, 1'b0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (mem_req) reqCyc++;
         if (err) checkVal("toReqAtErr", 128'(mem_req), 0);
      end
      checkVal("toReqCycles", reqCyc, 15);
      checkVal("toErrPulses", errCount - errBefore, 1);
      checkVal("toIdle", 128'(busy), 0);
      checkVal("toWrites", wrCount, 2);

      // Flush with beat 2 outstanding, then a fresh refill
      memOn = 1'b1;
      delayQ = '{0, 0, 30};
      @(posedge clk);
      #1 driveMiss(5'd9, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (beatSeen == 2) begin
            found = 1'b1;
            break;
         end
      end
      checkVal("flBeats", 128'(found), 1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      checkVal("flDrainReq", 128'(mem_req), 0);
      checkVal("flDrainBusy", 128'(busy), 1);
      @(posedge clk);
      #1 forceValid = 1'b1;
      @(negedge clk);
      checkVal("flStillDrain", 128'(busy), 1);
      @(posedge clk);
      #1 forceValid = 1'b0;
      @(negedge clk);
      checkVal("flIdle", 128'(busy), 0);
      checkVal("flNoWrite", wrCount, 2);
      delayQ.delete();
      @(posedge clk);
      #1 driveMiss(5'd17, 1'b1);
      @(negedge clk);
      checkVal("flNewBase", 128'(mem_addr), 16);
      waitIdle(20);
      checkVal("flNewWrites", wrCount, 3);

      // Asynchronous reset in the middle of a fill
      delayQ = '{0, 0, 0, 40};
      @(posedge clk);
      #1 driveMiss(5'd26, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (beatSeen == 3) begin
            found = 1'b1;
            break;
         end
      end
      checkVal("arBeats", 128'(found), 1);
      #2 rst_n = 1'b0;
      #1;
      checkVal("arReq", 128'(mem_req), 0);
      checkVal("arAddr", 128'(mem_addr), 0);
      checkVal("arBusy", 128'(busy), 0);
      checkVal("arLine", wr_line, 0);
      checkVal("arTag", 128'(wr_tag), 0);
      checkVal("arWrErr", 128'({wr_en, err}), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 forceValid = 1'b1;
      @(posedge clk);
      #1 forceValid = 1'b0;
      repeat (8) @(negedge clk);
      checkVal("arStrayBusy", 128'(busy), 0);
      checkVal("arStrayReq", 128'(mem_req), 0);
      checkVal("arWrites", wrCount, 3);

      // Second miss presented while filling pc 4
      delayQ = '{2, 2, 2, 2};
      @(posedge clk);
      #1 driveMiss(5'd4, 1'b1);
      repeat (2) @(negedge clk);
      miss    = 1'b1;
      miss_pc = 5'd8;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (mem_req) checkVal("mbLineAddr", 128'(mem_addr[4:2]), 1);
         if (wr_en) begin
            found = 1'b1;
            break;
         end
      end
      checkVal("mbWrSeen", 128'(found), 1);
      miss = 1'b0;
      waitIdle(10);
      checkVal("mbWrites", wrCount, 4);

      checkVal("pendingEnd", expQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
